id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage miniRV pipeline, directly downstream of the ID-stage hazard/forwarding unit.
- Selects forwarded or register-file operands per source and latches them with ID control fields into EX-stage registers.
- Inserts a bubble on load-use stall or branch/jump flush.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage_reg.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: resolves forwarded operands, latches ID control into EX,
// and replaces the ID instruction with a bubble on load-use stall or branch/jump flush.
module id_ex_stage_reg #(
    parameter int          CNT_W    = 16,
    parameter logic [2:0]  NOP_WSEL = 3'b011
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      id_ext,
    input  logic [31:0]      id_rD1,
    input  logic [31:0]      id_rD2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic [2:0]       id_rf_wsel,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alub_sel,
    input  logic             id_dram_we,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             forward_op1,
    input  logic             forward_op2,
    input  logic [31:0]      rD1_forward,
    input  logic [31:0]      rD2_forward,
    input  logic             stop,
    input  logic             flush,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_ext,
    output logic [31:0]      ex_op1,
    output logic [31:0]      ex_op2,
    output logic [4:0]       ex_rd,
    output logic             ex_rf_we,
    output logic [2:0]       ex_rf_wsel,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alub_sel,
    output logic             ex_dram_we,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [CNT_W-1:0] bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic             valid_d,   valid_q;
    logic [31:0]      pc_d,      pc_q;
    logic [31:0]      pc4_d,     pc4_q;
    logic [31:0]      ext_d,     ext_q;
    logic [31:0]      op1_d,     op1_q;
    logic [31:0]      op2_d,     op2_q;
    logic [4:0]       rd_d,      rd_q;
    logic             rf_we_d,   rf_we_q;
    logic [2:0]       rf_wsel_d, rf_wsel_q;
    logic [3:0]       alu_op_d,  alu_op_q;
    logic             alub_sel_d, alub_sel_q;
    logic             dram_we_d, dram_we_q;
    logic             branch_d,  branch_q;
    logic             jump_d,    jump_q;
    logic [CNT_W-1:0] cnt_d,     cnt_q;

    always_comb begin
        valid_d    = id_valid;
        pc_d       = id_pc;
        pc4_d      = id_pc4;
        ext_d      = id_ext;
        op1_d      = forward_op1 ? rD1_forward : id_rD1;
        op2_d      = forward_op2 ? rD2_forward : id_rD2;
        rd_d       = id_rd;
        rf_we_d    = id_rf_we & id_valid;
        rf_wsel_d  = id_rf_wsel;
        alu_op_d   = id_alu_op;
        alub_sel_d = id_alub_sel;
        dram_we_d  = id_dram_we & id_valid;
        branch_d   = id_branch;
        jump_d     = id_jump;
        cnt_d      = cnt_q;
        // Stall and flush share one bubble; the stalled instruction is re-presented by IF/ID.
        if (flush || stop) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            pc4_d      = '0;
            ext_d      = '0;
            op1_d      = '0;
            op2_d      = '0;
            rd_d       = '0;
            rf_we_d    = 1'b0;
            rf_wsel_d  = NOP_WSEL;
            alu_op_d   = '0;
            alub_sel_d = 1'b0;
            dram_we_d  = 1'b0;
            branch_d   = 1'b0;
            jump_d     = 1'b0;
            cnt_d      = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc4_q      <= '0;
            ext_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            rd_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= NOP_WSEL;
            alu_op_q   <= '0;
            alub_sel_q <= 1'b0;
            dram_we_q  <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            ext_q      <= ext_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rd_q       <= rd_d;
            rf_we_q    <= rf_we_d;
            rf_wsel_q  <= rf_wsel_d;
            alu_op_q   <= alu_op_d;
            alub_sel_q <= alub_sel_d;
            dram_we_q  <= dram_we_d;
            branch_q   <= branch_d;
            jump_q     <= jump_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_pc4      = pc4_q;
    assign ex_ext      = ext_q;
    assign ex_op1      = op1_q;
    assign ex_op2      = op2_q;
    assign ex_rd       = rd_q;
    assign ex_rf_we    = rf_we_q;
    assign ex_rf_wsel  = rf_wsel_q;
    assign ex_alu_op   = alu_op_q;
    assign ex_alub_sel = alub_sel_q;
    assign ex_dram_we  = dram_we_q;
    assign ex_branch   = branch_q;
    assign ex_jump     = jump_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: a 16-bit-counter instance and a 4-bit-counter
// instance share the same stimulus so counter saturation can be reached quickly.
module tb_id_ex_stage_reg;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        id_valid;
    logic [31:0] id_pc, id_pc4, id_ext, id_rD1, id_rD2;
    logic [4:0]  id_rd;
    logic        id_rf_we;
    logic [2:0]  id_rf_wsel;
    logic [3:0]  id_alu_op;
    logic        id_alub_sel, id_dram_we, id_branch, id_jump;
    logic        forward_op1, forward_op2;
    logic [31:0] rD1_forward, rD2_forward;
    logic        stop, flush;

    logic        ex_valid, ex_rf_we, ex_alub_sel, ex_dram_we, ex_branch, ex_jump;
    logic [31:0] ex_pc, ex_pc4, ex_ext, ex_op1, ex_op2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_rf_wsel;
    logic [3:0]  ex_alu_op;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_rf_we, s_alub_sel, s_dram_we, s_branch, s_jump;
    logic [31:0] s_pc, s_pc4, s_ext, s_op1, s_op2;
    logic [4:0]  s_rd;
    logic [2:0]  s_rf_wsel;
    logic [3:0]  s_alu_op;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    id_ex_stage_reg #(.CNT_W(16), .NOP_WSEL(3'b011)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_ext(id_ext),
        .id_rD1(id_rD1), .id_rD2(id_rD2), .id_rd(id_rd),
        .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel), .id_alu_op(id_alu_op),
        .id_alub_sel(id_alub_sel), .id_dram_we(id_dram_we),
        .id_branch(id_branch), .id_jump(id_jump),
        .forward_op1(forward_op1), .forward_op2(forward_op2),
        .rD1_forward(rD1_forward), .rD2_forward(rD2_forward),
        .stop(stop), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_ext(ex_ext),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
        .ex_rf_wsel(ex_rf_wsel), .ex_alu_op(ex_alu_op), .ex_alub_sel(ex_alub_sel),
        .ex_dram_we(ex_dram_we), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(.CNT_W(4), .NOP_WSEL(3'b011)) dut4 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_ext(id_ext),
        .id_rD1(id_rD1), .id_rD2(id_rD2), .id_rd(id_rd),
        .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel), .id_alu_op(id_alu_op),
        .id_alub_sel(id_alub_sel), .id_dram_we(id_dram_we),
        .id_branch(id_branch), .id_jump(id_jump),
        .forward_op1(forward_op1), .forward_op2(forward_op2),
        .rD1_forward(rD1_forward), .rD2_forward(rD2_forward),
        .stop(stop), .flush(flush),
        .ex_valid(s_valid), .ex_pc(s_pc), .ex_pc4(s_pc4), .ex_ext(s_ext),
        .ex_op1(s_op1), .ex_op2(s_op2), .ex_rd(s_rd), .ex_rf_we(s_rf_we),
        .ex_rf_wsel(s_rf_wsel), .ex_alu_op(s_alu_op), .ex_alub_sel(s_alub_sel),
        .ex_dram_we(s_dram_we), .ex_branch(s_branch), .ex_jump(s_jump),
        .bubble_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it, away from the edge.
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"},   {31'd0, ex_valid},    32'd0);
        check({tag, ".pc"},      ex_pc,                32'd0);
        check({tag, ".pc4"},     ex_pc4,               32'd0);
        check({tag, ".ext"},     ex_ext,               32'd0);
        check({tag, ".op1"},     ex_op1,               32'd0);
        check({tag, ".op2"},     ex_op2,               32'd0);
        check({tag, ".rd"},      {27'd0, ex_rd},       32'd0);
        check({tag, ".rf_we"},   {31'd0, ex_rf_we},    32'd0);
        check({tag, ".wsel"},    {29'd0, ex_rf_wsel},  32'd3);
        check({tag, ".alu_op"},  {28'd0, ex_alu_op},   32'd0);
        check({tag, ".alub"},    {31'd0, ex_alub_sel}, 32'd0);
        check({tag, ".dram_we"}, {31'd0, ex_dram_we},  32'd0);
        check({tag, ".branch"},  {31'd0, ex_branch},   32'd0);
        check({tag, ".jump"},    {31'd0, ex_jump},     32'd0);
    endtask

    initial begin
        // Reset with every ID input nonzero
        #1;
        cpu_rst = 1'b1; id_valid = 1'b1;
        id_pc = 32'h0000_0200; id_pc4 = 32'h0000_0204; id_ext = 32'hFFFF_FFF0;
        id_rD1 = 32'h0000_0011; id_rD2 = 32'h0000_0022; id_rd = 5'd7;
        id_rf_we = 1'b1; id_rf_wsel = 3'b010; id_alu_op = 4'hA; id_alub_sel = 1'b1;
        id_dram_we = 1'b1; id_branch = 1'b1; id_jump = 1'b1;
        forward_op1 = 1'b1; forward_op2 = 1'b1;
        rD1_forward = 32'h0000_00AA; rD2_forward = 32'h0000_00BB;
        stop = 1'b1; flush = 1'b1;
        step(); step();
        check_cleared("rst");
        check("rst.cnt", {16'd0, bubble_cnt}, 32'd0);
        check("rst.cnt4", {28'd0, s_cnt}, 32'd0);

        // Forwarding on rs1 only
        cpu_rst = 1'b0; stop = 1'b0; flush = 1'b0;
        forward_op1 = 1'b1; forward_op2 = 1'b0; id_dram_we = 1'b0; id_jump = 1'b0;
        step();
        check("fwd.op1", ex_op1, 32'h0000_00AA);
        check("fwd.op2", ex_op2, 32'h0000_0022);
        check("fwd.valid", {31'd0, ex_valid}, 32'd1);
        check("fwd.pc", ex_pc, 32'h0000_0200);
        check("fwd.pc4", ex_pc4, 32'h0000_0204);
        check("fwd.ext", ex_ext, 32'hFFFF_FFF0);
        check("fwd.rd", {27'd0, ex_rd}, 32'd7);
        check("fwd.wsel", {29'd0, ex_rf_wsel}, 32'd2);
        check("fwd.alu_op", {28'd0, ex_alu_op}, 32'hA);
        check("fwd.alub", {31'd0, ex_alub_sel}, 32'd1);
        check("fwd.branch", {31'd0, ex_branch}, 32'd1);
        check("fwd.jump", {31'd0, ex_jump}, 32'd0);
        check("fwd.dram_we", {31'd0, ex_dram_we}, 32'd0);
        check("fwd.cnt", {16'd0, bubble_cnt}, 32'd0);

        // rs2 forwarded, rs1 from register file
        forward_op1 = 1'b0; forward_op2 = 1'b1;
        step();
        check("fwd2.op1", ex_op1, 32'h0000_0011);
        check("fwd2.op2", ex_op2, 32'h0000_00BB);

        // Load-use stall: load, bubble, reload
        forward_op2 = 1'b0; id_rd = 5'd5; id_rf_we = 1'b1; id_pc = 32'h0000_0100;
        id_branch = 1'b0;
        step();
        check("ld.rd", {27'd0, ex_rd}, 32'd5);
        check("ld.rf_we", {31'd0, ex_rf_we}, 32'd1);
        stop = 1'b1;
        step();
        check_cleared("stall");
        check("stall.cnt", {16'd0, bubble_cnt}, 32'd1);
        stop = 1'b0;
        step();
        check("reload.pc", ex_pc, 32'h0000_0100);
        check("reload.valid", {31'd0, ex_valid}, 32'd1);
        check("reload.rd", {27'd0, ex_rd}, 32'd5);
        check("reload.cnt", {16'd0, bubble_cnt}, 32'd1);

        // Flush together with stop counts once
        id_dram_we = 1'b1; flush = 1'b1; stop = 1'b1;
        step();
        check("fs.dram_we", {31'd0, ex_dram_we}, 32'd0);
        check("fs.valid", {31'd0, ex_valid}, 32'd0);
        check("fs.cnt", {16'd0, bubble_cnt}, 32'd2);
        stop = 1'b0;
        step();
        check("fl.pc", ex_pc, 32'd0);
        check("fl.wsel", {29'd0, ex_rf_wsel}, 32'd3);
        check("fl.cnt", {16'd0, bubble_cnt}, 32'd3);

        // Invalid ID instruction suppresses write enables without a bubble count
        flush = 1'b0; id_valid = 1'b0; id_rf_we = 1'b1; id_dram_we = 1'b1;
        step();
        check("inv.rf_we", {31'd0, ex_rf_we}, 32'd0);
        check("inv.dram_we", {31'd0, ex_dram_we}, 32'd0);
        check("inv.valid", {31'd0, ex_valid}, 32'd0);
        check("inv.rd", {27'd0, ex_rd}, 32'd5);
        check("inv.pc", ex_pc, 32'h0000_0100);
        check("inv.cnt", {16'd0, bubble_cnt}, 32'd3);
        check("inv.cnt4", {28'd0, s_cnt}, 32'd3);

        // 20 consecutive stalls: 4-bit counter saturates, 16-bit keeps counting
        id_valid = 1'b1; stop = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat.cnt4", {28'd0, s_cnt}, 32'hF);
        check("sat.cnt", {16'd0, bubble_cnt}, 32'd23);
        step();
        check("sat.hold4", {28'd0, s_cnt}, 32'hF);
        check("sat.cnt24", {16'd0, bubble_cnt}, 32'd24);

        // Reset mid-stall clears the counters and the pipeline slot
        cpu_rst = 1'b1;
        step();
        check("rst2.cnt4", {28'd0, s_cnt}, 32'd0);
        check("rst2.cnt", {16'd0, bubble_cnt}, 32'd0);
        check("rst2.wsel", {29'd0, ex_rf_wsel}, 32'd3);

        // First post-reset edge loads normally
        cpu_rst = 1'b0; stop = 1'b0; id_pc = 32'h0000_0300; id_rf_we = 1'b1;
        step();
        check("post.valid", {31'd0, ex_valid}, 32'd1);
        check("post.pc", ex_pc, 32'h0000_0300);
        check("post.rf_we", {31'd0, ex_rf_we}, 32'd1);
        check("post.cnt", {16'd0, bubble_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
